// File: rtl/score_tally_feed.sv
// score_tally_feed
//   Producer side of the on-screen number display. Tallies classification
//   results (label vs. predicted digit) into tested/correct counters. Once per
//   frame it snapshots the counters, runs a fixed-latency restoring divide to
//   get floor(correct*100/tested), and latches a consistent set of three
//   print values for the text-draw block.
//
// Ports:
//   CLOCK_50         in   system clock
//   RST              in   synchronous reset, active-high
//   result_valid     in   strobe: result_label/result_pred are valid
//   result_label     in   [3:0] expected digit
//   result_pred      in   [3:0] predicted digit
//   clear            in   synchronous run restart (zeroes all, aborts divide)
//   frame_sync       in   one-cycle pulse in vertical blank, starts an update
//   print_val_total  out  [12:0] latched tested count
//   print_val_pct    out  [7:0]  latched accuracy percentage 0..100
//   print_val_last   out  [7:0]  latched last prediction, zero-extended
//   busy             out  update sequence in progress
//   done             out  tested count has reached TEST_COUNT
module score_tally_feed #(
  parameter int TEST_COUNT = 4992,
  parameter int DIV_BITS   = 20
) (
  input  logic        CLOCK_50,
  input  logic        RST,
  input  logic        result_valid,
  input  logic [3:0]  result_label,
  input  logic [3:0]  result_pred,
  input  logic        clear,
  input  logic        frame_sync,
  output logic [12:0] print_val_total,
  output logic [7:0]  print_val_pct,
  output logic [7:0]  print_val_last,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(DIV_BITS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, WRITE} state_t;

  state_t              state_reg;
  logic [12:0]         tested_reg, tested_next;
  logic [12:0]         correct_reg, correct_next;
  logic [3:0]          last_reg, last_next;
  logic                accept;

  logic [12:0]         snap_tested_reg;
  logic [12:0]         snap_correct_reg;
  logic [3:0]          snap_last_reg;

  // quot_reg starts as the dividend; each step shifts its MSB into the
  // remainder and shifts the new quotient bit in at the bottom, so after
  // DIV_BITS steps it holds the full quotient.
  logic [DIV_BITS-1:0] quot_reg;
  logic [12:0]         divisor_reg;
  logic [12:0]         rem_reg;
  logic [CW-1:0]       iter_reg;

  logic [13:0]         rem_shift;
  logic                q_bit;
  logic [12:0]         rem_new;

  // Counting path. The next-state values are also what a frame_sync snapshot
  // captures, so a result accepted on the same edge is included.
  always_comb begin
    accept       = result_valid && (tested_reg < 13'(TEST_COUNT));
    tested_next  = tested_reg;
    correct_next = correct_reg;
    last_next    = last_reg;
    if (accept) begin
      tested_next = tested_reg + 13'd1;
      if (result_label == result_pred)
        correct_next = correct_reg + 13'd1;
      last_next = result_pred;
    end
  end

  // One restoring-divide step. The remainder stays below the divisor, so the
  // subtraction result always fits 13 bits; with a zero divisor the result is
  // discarded at WRITE, so the truncation there is harmless.
  always_comb begin
    rem_shift = {rem_reg, quot_reg[DIV_BITS-1]};
    q_bit     = (rem_shift >= {1'b0, divisor_reg});
    rem_new   = q_bit ? 13'(rem_shift - {1'b0, divisor_reg}) : rem_shift[12:0];
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST || clear) begin
      state_reg        <= IDLE;
      tested_reg       <= '0;
      correct_reg      <= '0;
      last_reg         <= '0;
      snap_tested_reg  <= '0;
      snap_correct_reg <= '0;
      snap_last_reg    <= '0;
      quot_reg         <= '0;
      divisor_reg      <= '0;
      rem_reg          <= '0;
      iter_reg         <= '0;
      print_val_total  <= '0;
      print_val_pct    <= '0;
      print_val_last   <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      tested_reg  <= tested_next;
      correct_reg <= correct_next;
      last_reg    <= last_next;
      done        <= (tested_next == 13'(TEST_COUNT));

      case (state_reg)
        IDLE: begin
          if (frame_sync) begin
            snap_tested_reg  <= tested_next;
            snap_correct_reg <= correct_next;
            snap_last_reg    <= last_next;
            busy             <= 1'b1;
            state_reg        <= LOAD;
          end
        end
        LOAD: begin
          quot_reg    <= DIV_BITS'(snap_correct_reg) * DIV_BITS'(7'd100);
          divisor_reg <= snap_tested_reg;
          rem_reg     <= '0;
          iter_reg    <= '0;
          state_reg   <= DIV;
        end
        DIV: begin
          quot_reg <= {quot_reg[DIV_BITS-2:0], q_bit};
          rem_reg  <= rem_new;
          iter_reg <= iter_reg + CW'(1);
          if (iter_reg == CW'(DIV_BITS - 1))
            state_reg <= WRITE;
        end
        WRITE: begin
          print_val_total <= snap_tested_reg;
          print_val_pct   <= (snap_tested_reg == 13'd0) ? 8'd0 : quot_reg[7:0];
          print_val_last  <= {4'd0, snap_last_reg};
          busy            <= 1'b0;
          state_reg       <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
